// File: rtl/eth_pkt_gen_pkg.sv
// Shared types, Ethernet length limits and beat/keep arithmetic for the
// eth_axis_pkt_gen traffic generator.
package eth_pkt_gen_pkg;

  localparam int AXIS_DATA_WIDTH = 512;
  localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  localparam logic [13:0] ETH_MIN_LEN   = 14'd60;
  localparam logic [13:0] ETH_MAX_LEN   = 14'd9600;
  localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [13:0] clamp_len(input logic [13:0] len);
    if (len < ETH_MIN_LEN) return ETH_MIN_LEN;
    if (len > ETH_MAX_LEN) return ETH_MAX_LEN;
    return len;
  endfunction

  // Frame length is already clamped, so the result always fits in 8 bits.
  function automatic logic [7:0] num_beats(input logic [13:0] len, input int bpb);
    int n;
    n = (int'(len) + bpb - 1) / bpb;
    return n[7:0];
  endfunction

  function automatic int last_beat_bytes(input logic [13:0] len, input int bpb);
    int r;
    r = int'(len) % bpb;
    return (r == 0) ? bpb : r;
  endfunction

endpackage

// File: rtl/eth_pkt_beat_fmt.sv
// Combinational formatter: builds one AXI-Stream beat (data/keep/last) of a
// test frame from the beat index, clamped length, MACs and sequence number.
module eth_pkt_beat_fmt
  import eth_pkt_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter logic [15:0] ETHERTYPE  = DEF_ETHERTYPE
) (
  input  logic [7:0]            i_beat,
  input  logic [13:0]           i_len,
  input  logic [47:0]           i_dst_mac,
  input  logic [47:0]           i_src_mac,
  input  logic [31:0]           i_seq,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic [KEEP_WIDTH-1:0] o_tkeep,
  output logic                  o_tlast
);

  logic [143:0] w_hdr;
  logic [15:0]  w_base;
  logic [15:0]  w_last_bytes;
  logic         w_last;

  // The 18 header bytes in wire order; byte b sits in the top byte after a left shift by 8*b.
  assign w_hdr        = {i_dst_mac, i_src_mac, ETHERTYPE, i_seq};
  assign w_base       = 16'(i_beat) * 16'(KEEP_WIDTH);
  assign w_last       = (i_beat == (num_beats(i_len, KEEP_WIDTH) - 8'd1));
  assign w_last_bytes = 16'(last_beat_bytes(i_len, KEEP_WIDTH));
  assign o_tlast      = w_last;

  function automatic logic [7:0] frame_byte(input logic [15:0] b, input logic [143:0] hdr);
    logic [143:0] sh;
    sh = hdr << {b[4:0], 3'b000};
    return (b < 16'd18) ? sh[143:136] : b[7:0];
  endfunction

  always_comb begin
    o_tdata = '0;
    o_tkeep = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (!w_last || (16'(i) < w_last_bytes)) begin
        o_tkeep[i]         = 1'b1;
        o_tdata[8*i +: 8]  = frame_byte(w_base + 16'(i), w_hdr);
      end
    end
  end

endmodule

// File: rtl/eth_axis_pkt_gen.sv
// Test-frame generator driving the CMAC TX AXI-Stream: run control FSM,
// frame/sequence counters and the registered output beat.
module eth_axis_pkt_gen
  import eth_pkt_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int          USER_WIDTH = 17,
  parameter logic [15:0] ETHERTYPE  = DEF_ETHERTYPE
) (
  input  logic                  clk_usr_logic_in,
  input  logic                  rstn_usr_logic_in,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic [47:0]           cfg_dst_mac_in,
  input  logic [47:0]           cfg_src_mac_in,
  input  logic [13:0]           cfg_frame_len_in,
  input  logic [31:0]           cfg_frame_count_in,
  input  logic [7:0]            cfg_ifg_cycles_in,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [31:0]           frames_sent_out,
  output state_t                dbg_state_out
);

  state_t r_state, w_nxt_state;
  logic [47:0] r_dst, r_src;
  logic [13:0] r_len;
  logic [31:0] r_count, r_seq, r_frames, w_nxt_seq, w_nxt_frames, w_frames_inc;
  logic [7:0]  r_ifg, r_gap, r_beat, w_nxt_gap, w_nxt_beat;
  logic        r_stop_pend, r_busy, r_done, r_tvalid, r_tlast;
  logic        w_nxt_stop_pend, w_nxt_busy, w_nxt_done, w_nxt_tvalid;
  logic        w_fire, w_load, w_latch;
  logic [DATA_WIDTH-1:0] r_tdata, w_fmt_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep, w_fmt_tkeep;
  logic        w_fmt_tlast;
  logic [13:0] w_fmt_len;
  logic [47:0] w_fmt_dst, w_fmt_src;

  // AXI-Stream: a beat transfers on a cycle with tvalid && tready; while tvalid is
  // high and tready low, tdata/tkeep/tlast/tuser hold, and tvalid never drops mid-frame.
  assign w_fire       = r_tvalid && m_axis_tready;
  assign w_frames_inc = r_frames + 32'd1;

  // While idle the first beat is formatted straight from the live config being latched.
  assign w_fmt_len = (r_state == ST_IDLE) ? clamp_len(cfg_frame_len_in) : r_len;
  assign w_fmt_dst = (r_state == ST_IDLE) ? cfg_dst_mac_in : r_dst;
  assign w_fmt_src = (r_state == ST_IDLE) ? cfg_src_mac_in : r_src;

  eth_pkt_beat_fmt #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .ETHERTYPE  (ETHERTYPE)
  ) u_fmt (
    .i_beat    (w_nxt_beat),
    .i_len     (w_fmt_len),
    .i_dst_mac (w_fmt_dst),
    .i_src_mac (w_fmt_src),
    .i_seq     (w_nxt_seq),
    .o_tdata   (w_fmt_tdata),
    .o_tkeep   (w_fmt_tkeep),
    .o_tlast   (w_fmt_tlast)
  );

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_seq       = r_seq;
    w_nxt_frames    = r_frames;
    w_nxt_beat      = r_beat;
    w_nxt_gap       = r_gap;
    w_nxt_stop_pend = r_stop_pend;
    w_nxt_busy      = r_busy;
    w_nxt_done      = 1'b0;
    w_nxt_tvalid    = r_tvalid;
    w_load          = 1'b0;
    w_latch         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          w_latch         = 1'b1;
          w_load          = 1'b1;
          w_nxt_seq       = '0;
          w_nxt_frames    = '0;
          w_nxt_beat      = '0;
          w_nxt_stop_pend = 1'b0;
          w_nxt_busy      = 1'b1;
          w_nxt_tvalid    = 1'b1;
          w_nxt_state     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (stop_in) w_nxt_stop_pend = 1'b1;
        if (w_fire) begin
          if (!r_tlast) begin
            w_nxt_beat = r_beat + 8'd1;
            w_load     = 1'b1;
          end else begin
            w_nxt_frames = w_frames_inc;
            w_nxt_seq    = r_seq + 32'd1;
            w_nxt_beat   = '0;
            if (((r_count != '0) && (w_frames_inc == r_count)) || r_stop_pend || stop_in) begin
              w_nxt_state  = ST_IDLE;
              w_nxt_tvalid = 1'b0;
              w_nxt_busy   = 1'b0;
              w_nxt_done   = 1'b1;
            end else if (r_ifg == '0) begin
              w_load = 1'b1;
            end else begin
              w_nxt_state  = ST_GAP;
              w_nxt_tvalid = 1'b0;
              w_nxt_gap    = r_ifg;
            end
          end
        end
      end
      ST_GAP: begin
        if (stop_in) begin
          w_nxt_state = ST_IDLE;
          w_nxt_busy  = 1'b0;
          w_nxt_done  = 1'b1;
        end else if (r_gap == 8'd1) begin
          w_nxt_state  = ST_SEND;
          w_nxt_tvalid = 1'b1;
          w_load       = 1'b1;
        end else begin
          w_nxt_gap = r_gap - 8'd1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_usr_logic_in or negedge rstn_usr_logic_in) begin
    if (!rstn_usr_logic_in) begin
      r_state     <= ST_IDLE;
      r_dst       <= '0;
      r_src       <= '0;
      r_len       <= '0;
      r_count     <= '0;
      r_ifg       <= '0;
      r_seq       <= '0;
      r_frames    <= '0;
      r_beat      <= '0;
      r_gap       <= '0;
      r_stop_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_seq       <= w_nxt_seq;
      r_frames    <= w_nxt_frames;
      r_beat      <= w_nxt_beat;
      r_gap       <= w_nxt_gap;
      r_stop_pend <= w_nxt_stop_pend;
      r_busy      <= w_nxt_busy;
      r_done      <= w_nxt_done;
      r_tvalid    <= w_nxt_tvalid;
      if (w_latch) begin
        r_dst   <= cfg_dst_mac_in;
        r_src   <= cfg_src_mac_in;
        r_len   <= w_fmt_len;
        r_count <= cfg_frame_count_in;
        r_ifg   <= cfg_ifg_cycles_in;
      end
      if (w_load) begin
        r_tdata <= w_fmt_tdata;
        r_tkeep <= w_fmt_tkeep;
        r_tlast <= w_fmt_tlast;
      end
    end
  end

  assign m_axis_tdata    = r_tdata;
  assign m_axis_tkeep    = r_tkeep;
  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tlast    = r_tlast;
  assign m_axis_tuser    = '0;
  assign busy_out        = r_busy;
  assign done_out        = r_done;
  assign frames_sent_out = r_frames;
  assign dbg_state_out   = r_state;

endmodule
